multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the RV32 core: walks each instruction through fetch, decode, execute, memory and writeback states, and drives the shared ALU, register file, PC and single unified memory port. It also handles a ready-based memory handshake with optional timeout. It sits between the instruction register (opcode source) and the datapath muxes/enables. It replaces the single-cycle decode path when the core is built with one memory port.

## Interface
- MEM_TIMEOUT, 0: maximum wait cycles per memory access; 0 disables the timeout.
- CNT_W, 32: width of the performance counters (used only with the macro).
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instruction[6:0] from the IR; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read.
- i_or_d  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write, pc_write, pc_write_cond, reg_write  out  1 each  register enables.
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = memory data register.
- pc_source  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- alu_src_a  out  2  ALU A operand: 00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b  out  2  ALU B operand: 00 = rs2, 01 = constant 4, 10 = immediate.
- aluop  out  2  00 = add, 01 = subtract (branch), 10 = R-type funct, 11 = I-type funct.
- instr_retired  out  1  one-cycle pulse when an instruction completes.
- halted, illegal_instr, bus_error  out  1 each  sticky status flags; cleared only by reset.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, HALT.
- FETCH:
  - Outputs: mem_req=1, i_or_d=0, alu_src_a=00, alu_src_b=01, aluop=00.
  - If mem_ready: ir_write=1, pc_write=1, pc_source=0, go to DECODE; otherwise hold.
- DECODE computes the branch target: alu_src_a=01, alu_src_b=10, aluop=00.
- DECODE dispatch on opcode:
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 0000011 or 0100011 → MEM_ADDR.
  - 1100011 → BRANCH.
  - Anything else → HALT with illegal_instr=1.
- EXEC_R: alu_src_a=10, alu_src_b=00, aluop=10 → ALU_WB.
- EXEC_I: alu_src_a=10, alu_src_b=10, aluop=11 → ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, instr_retired=1 → FETCH.
- MEM_ADDR: alu_src_a=10, alu_src_b=10, aluop=00. Go to MEM_READ if opcode is 0000011, else MEM_WRITE.
- MEM_READ: mem_req=1, i_or_d=1, mem_we=0. If mem_ready → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, instr_retired=1 → FETCH.
- MEM_WRITE: mem_req=1, i_or_d=1, mem_we=1. If mem_ready: instr_retired=1, go to FETCH.
- BRANCH:
  - Outputs: alu_src_a=10, alu_src_b=00, aluop=01, pc_write_cond=1, pc_source=1, instr_retired=1 → FETCH.
  - The datapath gates the PC write with zero.
  - Only beq is sequenced; funct3 is not decoded.
- HALT: all enables 0, halted=1; the block stays in HALT until reset.
- Unlisted outputs are 0 in every state.

## Timing
- All outputs are combinational from state. Exception: ir_write and pc_write in FETCH, and instr_retired in MEM_WRITE, are additionally gated by mem_ready.
- Handshake:
  - mem_req stays high until the cycle mem_ready=1; the access completes in that cycle.
  - mem_ready is ignored while mem_req=0.
  - Address and mem_we are stable for the whole request.
- Zero-wait latency: R/I-type 4 cycles, lw 5, sw 4, beq 3. Each memory wait cycle adds 1.
- Wait counter:
  - Clears on entry to any memory state and increments each cycle mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT: go to HALT with bus_error=1.
  - If mem_ready and the timeout coincide in the same cycle, mem_ready wins.
- While reset=1: state forced to FETCH, counter 0, sticky flags 0, all outputs 0.
  - The first cycle after reset deasserts drives mem_req=1 from FETCH.
  - A reset during a pending access drops mem_req immediately; memory must abandon the transfer.

## Configuration
- PERF_COUNTERS_EN defined: adds outputs cycle_count and instret_count, each CNT_W wide.
  - Both reset to 0 and wrap modulo 2^CNT_W.
  - cycle_count increments every non-reset cycle, including HALT.
  - instret_count increments on each instr_retired pulse.
- Not defined: these ports and their registers are absent; all other behaviour is identical.

## Structure
- Shared package/header riscv_ctrl_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
  - state encoding;
  - aluop, alu_src_a and alu_src_b encodings.
- One sub-module: ctrl_perf_counters, instantiated only under PERF_COUNTERS_EN.

## Test plan
- Reset, then mem_ready=1 every cycle, opcode=0110011: FETCH, DECODE, EXEC_R, ALU_WB, then FETCH. reg_write=1 and instr_retired=1 only in cycle 4.
- lw (0000011) with mem_ready low 3 cycles in MEM_READ: mem_req=1, i_or_d=1 held throughout; MEM_WB follows; total 8 cycles.
- beq (1100011): pc_write_cond=1, pc_source=1, aluop=01 in cycle 3. sw (0100011): mem_we=1 and instr_retired fire in the mem_ready cycle.
- opcode=1111111 in DECODE: next cycle halted=1, illegal_instr=1, all enables 0; this holds until reset, then FETCH resumes.
- MEM_TIMEOUT=4, mem_ready never rises during fetch: bus_error=1 and HALT after 4 wait cycles. Repeat with mem_ready rising in cycle 4: no error.
- PERF_COUNTERS_EN, CNT_W=4: 20 cycles give cycle_count=4 (wrapped); 3 R-type instructions give instret_count=3. Reset asserted mid-MEM_READ: mem_req=0 in that cycle, counters 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32 multi-cycle control sequencer: opcodes,
// FSM states, ALU operand/operation selects and the control-word payload.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_ALU_WB    = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_READ  = 4'd6,
        S_MEM_WB    = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_BRANCH    = 4'd9,
        S_HALT      = 4'd10
    } state_t;

    // Datapath control word decoded from the current state each cycle.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_source;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic       instr_retired;
    } ctrl_t;

endpackage

// File: rtl/ctrl_perf_counters.sv
// Cycle and retired-instruction counters for the multi-cycle sequencer.
// Present only when PERF_COUNTERS_EN is defined.
`ifdef PERF_COUNTERS_EN
module ctrl_perf_counters #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    // Free-running counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign cycle_count   = reset ? '0 : cycle_q;
    assign instret_count = reset ? '0 : instret_q;

endmodule
`endif

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 control FSM driving ALU, register file, PC and one memory port.
// Optional PERF_COUNTERS_EN adds cycle_count/instret_count outputs.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             pc_source,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       aluop,
    output logic             instr_retired,
    output logic             halted,
    output logic             illegal_instr,
    output logic             bus_error
`ifdef PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
`endif
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t            state;
    state_t            state_next;
    ctrl_t             ctl;
    ctrl_t             ctl_out;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_mem_state;
    logic              timeout_hit;
    logic              set_illegal;
    logic              set_bus_err;
    logic              halted_q;
    logic              illegal_q;
    logic              bus_err_q;
    logic              unused_zero;

    // The branch condition is applied by the datapath, not by the sequencer.
    assign unused_zero = zero;

    assign in_mem_state = (state == S_FETCH) || (state == S_MEM_READ) ||
                          (state == S_MEM_WRITE);

    // Fires on the wait cycle that would bring the counter to MEM_TIMEOUT; mem_ready wins.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                         (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        ctl         = '0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        case (state)
            S_FETCH: begin
                ctl.mem_req   = 1'b1;
                ctl.i_or_d    = 1'b0;
                ctl.alu_src_a = SRC_A_PC;
                ctl.alu_src_b = SRC_B_FOUR;
                ctl.aluop     = ALUOP_ADD;
                if (mem_ready) begin
                    ctl.ir_write  = 1'b1;
                    ctl.pc_write  = 1'b1;
                    ctl.pc_source = 1'b0;
                    state_next    = S_DECODE;
                end else if (timeout_hit) begin
                    set_bus_err = 1'b1;
                    state_next  = S_HALT;
                end
            end
            S_DECODE: begin
                ctl.alu_src_a = SRC_A_OLD_PC;
                ctl.alu_src_b = SRC_B_IMM;
                ctl.aluop     = ALUOP_ADD;
                case (opcode)
                    OP_R:              state_next = S_EXEC_R;
                    OP_I:              state_next = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
                    OP_BRANCH:         state_next = S_BRANCH;
                    default: begin
                        set_illegal = 1'b1;
                        state_next  = S_HALT;
                    end
                endcase
            end
            S_EXEC_R: begin
                ctl.alu_src_a = SRC_A_RS1;
                ctl.alu_src_b = SRC_B_RS2;
                ctl.aluop     = ALUOP_RTYPE;
                state_next    = S_ALU_WB;
            end
            S_EXEC_I: begin
                ctl.alu_src_a = SRC_A_RS1;
                ctl.alu_src_b = SRC_B_IMM;
                ctl.aluop     = ALUOP_ITYPE;
                state_next    = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctl.reg_write     = 1'b1;
                ctl.mem_to_reg    = 1'b0;
                ctl.instr_retired = 1'b1;
                state_next        = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a = SRC_A_RS1;
                ctl.alu_src_b = SRC_B_IMM;
                ctl.aluop     = ALUOP_ADD;
                state_next    = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                ctl.mem_req = 1'b1;
                ctl.i_or_d  = 1'b1;
                ctl.mem_we  = 1'b0;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (timeout_hit) begin
                    set_bus_err = 1'b1;
                    state_next  = S_HALT;
                end
            end
            S_MEM_WB: begin
                ctl.reg_write     = 1'b1;
                ctl.mem_to_reg    = 1'b1;
                ctl.instr_retired = 1'b1;
                state_next        = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctl.mem_req = 1'b1;
                ctl.i_or_d  = 1'b1;
                ctl.mem_we  = 1'b1;
                if (mem_ready) begin
                    ctl.instr_retired = 1'b1;
                    state_next        = S_FETCH;
                end else if (timeout_hit) begin
                    set_bus_err = 1'b1;
                    state_next  = S_HALT;
                end
            end
            S_BRANCH: begin
                ctl.alu_src_a     = SRC_A_RS1;
                ctl.alu_src_b     = SRC_B_RS2;
                ctl.aluop         = ALUOP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = 1'b1;
                ctl.instr_retired = 1'b1;
                state_next        = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Wait counter restarts on every state change; sticky flags latch on entry to HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (in_mem_state && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (state_next == S_HALT) begin
                halted_q <= 1'b1;
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_bus_err) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Reset silences everything at once, including a pending memory request.
    assign ctl_out = reset ? '0 : ctl;

    assign mem_req       = ctl_out.mem_req;
    assign mem_we        = ctl_out.mem_we;
    assign i_or_d        = ctl_out.i_or_d;
    assign ir_write      = ctl_out.ir_write;
    assign pc_write      = ctl_out.pc_write;
    assign pc_write_cond = ctl_out.pc_write_cond;
    assign reg_write     = ctl_out.reg_write;
    assign mem_to_reg    = ctl_out.mem_to_reg;
    assign pc_source     = ctl_out.pc_source;
    assign alu_src_a     = ctl_out.alu_src_a;
    assign alu_src_b     = ctl_out.alu_src_b;
    assign aluop         = ctl_out.aluop;
    assign instr_retired = ctl_out.instr_retired;
    assign halted        = halted_q  & ~reset;
    assign illegal_instr = illegal_q & ~reset;
    assign bus_error     = bus_err_q & ~reset;

`ifdef PERF_COUNTERS_EN
    ctrl_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk           (clk),
        .reset         (reset),
        .retire        (ctl.instr_retired),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );
`else
    // CNT_W only sizes the counter ports, which this build omits.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, scoreboard-checked bench for multicycle_control (MEM_TIMEOUT=4).
// Counter checks are compiled in when PERF_COUNTERS_EN is defined.
module tb_multicycle_control;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam int unsigned TB_CNT_W   = 4;

    localparam logic [6:0] TB_OP_R   = 7'b0110011;
    localparam logic [6:0] TB_OP_I   = 7'b0010011;
    localparam logic [6:0] TB_OP_LW  = 7'b0000011;
    localparam logic [6:0] TB_OP_SW  = 7'b0100011;
    localparam logic [6:0] TB_OP_BEQ = 7'b1100011;
    localparam logic [6:0] TB_OP_BAD = 7'b1111111;

    typedef enum int {T_RST, T_F, T_D, T_ER, T_EI, T_AW, T_MA, T_MR, T_MWB, T_MW, T_BR, T_H} tag_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_source;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] aluop;
        logic       retired;
        logic       halted;
        logic       illegal;
        logic       bus_err;
    } obs_t;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic       reg_write, mem_to_reg, pc_source, instr_retired;
    logic       halted, illegal_instr, bus_error;
    logic [1:0] alu_src_a, alu_src_b, aluop;
`ifdef PERF_COUNTERS_EN
    logic [TB_CNT_W-1:0] cycle_count, instret_count;
`endif

    int   checks   = 0;
    int   failures = 0;
    logic exp_halt, exp_ill, exp_bus;
    obs_t exp_q[$];

    multicycle_control #(
        .MEM_TIMEOUT (TB_TIMEOUT),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .aluop         (aluop),
        .instr_retired (instr_retired),
        .halted        (halted),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error)
`ifdef PERF_COUNTERS_EN
        ,
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference control word for one cycle in a given sequencer step.
    function automatic obs_t expv(input tag_e tag, input logic rdy);
        obs_t v;
        v = '0;
        case (tag)
            T_F:   begin v.mem_req = 1'b1; v.src_b = 2'b01; v.ir_write = rdy; v.pc_write = rdy; end
            T_D:   begin v.src_a = 2'b01; v.src_b = 2'b10; end
            T_ER:  begin v.src_a = 2'b10; v.src_b = 2'b00; v.aluop = 2'b10; end
            T_EI:  begin v.src_a = 2'b10; v.src_b = 2'b10; v.aluop = 2'b11; end
            T_AW:  begin v.reg_write = 1'b1; v.retired = 1'b1; end
            T_MA:  begin v.src_a = 2'b10; v.src_b = 2'b10; end
            T_MR:  begin v.mem_req = 1'b1; v.i_or_d = 1'b1; end
            T_MWB: begin v.reg_write = 1'b1; v.mem_to_reg = 1'b1; v.retired = 1'b1; end
            T_MW:  begin v.mem_req = 1'b1; v.i_or_d = 1'b1; v.mem_we = 1'b1; v.retired = rdy; end
            T_BR:  begin v.src_a = 2'b10; v.aluop = 2'b01; v.pc_write_cond = 1'b1;
                         v.pc_source = 1'b1; v.retired = 1'b1; end
            default: ;
        endcase
        if (tag != T_RST) begin
            v.halted  = exp_halt;
            v.illegal = exp_ill;
            v.bus_err = exp_bus;
        end
        return v;
    endfunction

    // One clock cycle: drive mem_ready, queue the expectation, compare mid-cycle.
    task automatic step(input tag_e tag, input logic rdy, input string name);
        obs_t got, e;
        mem_ready = rdy;
        exp_q.push_back(expv(tag, rdy));
        #2;
        got = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, reg_write,
               mem_to_reg, pc_source, alu_src_a, alu_src_b, aluop, instr_retired,
               halted, illegal_instr, bus_error};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s: got=%h expected=queued_entry", name, got);
        end else begin
            e = exp_q.pop_front();
            assert (got === e) else begin
                failures++;
                $error("FAIL %s: got=%h expected=%h", name, got, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_val(input string name, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic run_r(input string name);
        opcode = TB_OP_R;
        step(T_F, 1'b1, {name, "_fetch"});
        step(T_D, 1'b1, {name, "_decode"});
        step(T_ER, 1'b1, {name, "_exec"});
        step(T_AW, 1'b1, {name, "_wb"});
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        step(T_RST, 1'b1, name);
        exp_halt = 1'b0;
        exp_ill  = 1'b0;
        exp_bus  = 1'b0;
        reset    = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = TB_OP_R;
        exp_halt  = 1'b0;
        exp_ill   = 1'b0;
        exp_bus   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        step(T_RST, 1'b1, "reset_a");
        step(T_RST, 1'b0, "reset_b");
        reset = 1'b0;

        run_r("rtype");

        opcode = TB_OP_I;
        step(T_F, 1'b1, "itype_fetch");
        step(T_D, 1'b1, "itype_decode");
        step(T_EI, 1'b1, "itype_exec");
        step(T_AW, 1'b1, "itype_wb");

        opcode = TB_OP_LW;
        step(T_F, 1'b1, "lw_fetch");
        step(T_D, 1'b1, "lw_decode");
        step(T_MA, 1'b1, "lw_addr");
        for (int i = 0; i < 3; i++) step(T_MR, 1'b0, "lw_read_wait");
        step(T_MR, 1'b1, "lw_read_done");
        step(T_MWB, 1'b1, "lw_wb");

        opcode = TB_OP_SW;
        step(T_F, 1'b0, "sw_fetch_wait");
        step(T_F, 1'b0, "sw_fetch_wait");
        step(T_F, 1'b1, "sw_fetch_done");
        step(T_D, 1'b1, "sw_decode");
        step(T_MA, 1'b1, "sw_addr");
        step(T_MW, 1'b0, "sw_write_wait");
        step(T_MW, 1'b1, "sw_write_done");

        opcode = TB_OP_BEQ;
        step(T_F, 1'b1, "beq_fetch");
        step(T_D, 1'b1, "beq_decode");
        step(T_BR, 1'b1, "beq_branch");

        opcode = TB_OP_R;
        for (int i = 0; i < 3; i++) step(T_F, 1'b0, "late_fetch_wait");
        step(T_F, 1'b1, "late_fetch_ready_c4");
        step(T_D, 1'b1, "late_decode");
        step(T_ER, 1'b1, "late_exec");
        step(T_AW, 1'b1, "late_wb");

        opcode = TB_OP_BAD;
        step(T_F, 1'b1, "bad_fetch");
        step(T_D, 1'b1, "bad_decode");
        exp_halt = 1'b1;
        exp_ill  = 1'b1;
        step(T_H, 1'b1, "bad_halt0");
        step(T_H, 1'b0, "bad_halt1");
        step(T_H, 1'b1, "bad_halt2");
        do_reset("bad_reset");

        run_r("resume");

        for (int i = 0; i < 4; i++) step(T_F, 1'b0, "to_fetch_wait");
        exp_halt = 1'b1;
        exp_bus  = 1'b1;
        step(T_H, 1'b1, "to_halt0");
        step(T_H, 1'b0, "to_halt1");
        do_reset("to_reset");

        opcode = TB_OP_LW;
        step(T_F, 1'b1, "abort_fetch");
        step(T_D, 1'b1, "abort_decode");
        step(T_MA, 1'b1, "abort_addr");
        step(T_MR, 1'b0, "abort_read_wait");
        reset = 1'b1;
`ifdef PERF_COUNTERS_EN
        #1;
        chk_val("perf_cycle_in_reset", int'(cycle_count), 0);
        chk_val("perf_instret_in_reset", int'(instret_count), 0);
`endif
        do_reset("abort_reset");

        for (int i = 0; i < 3; i++) run_r("perf_r");
`ifdef PERF_COUNTERS_EN
        #1;
        chk_val("perf_cycle_12", int'(cycle_count), 12);
        chk_val("perf_instret_3", int'(instret_count), 3);
`endif
        for (int i = 0; i < 2; i++) run_r("perf_r_more");
`ifdef PERF_COUNTERS_EN
        #1;
        chk_val("perf_cycle_wrap", int'(cycle_count), 20 % 16);
        chk_val("perf_instret_5", int'(instret_count), 5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
